// File: rtl/filter_pkg.sv
// Shared defaults and scheduler state type for the half-band decimator input side.
// Optional pair statistics are enabled with HBF_SCHED_STATS_EN (see hbf_sched).
package filter_pkg;

    localparam int unsigned INPUT_SAMPLE_DATA_WIDTH = 16;
    localparam int unsigned COEFF_DATA_WIDTH        = 16;
    localparam int unsigned FILTER_ORDER            = 8;

    typedef enum logic [1:0] {
        S_EVEN  = 2'd0,
        S_ODD   = 2'd1,
        S_ISSUE = 2'd2
    } sched_state_t;

    // Saturating 16-bit increment used by the pair counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

endpackage

// File: rtl/hbf_coeff_bank.sv
// Shadow/active coefficient registers; a requested commit copies shadow to active
// only on a boundary strobe so one output never sees two coefficient sets.
module hbf_coeff_bank #(
    parameter int unsigned COEFF_DATA_WIDTH = filter_pkg::COEFF_DATA_WIDTH,
    parameter int unsigned FILTER_ORDER     = filter_pkg::FILTER_ORDER
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [$clog2(FILTER_ORDER)-1:0] wr_addr,
    input  logic [COEFF_DATA_WIDTH-1:0]     wr_data,
    input  logic                            commit,
    input  logic                            boundary,
    output logic                            commit_pending,
    output logic [COEFF_DATA_WIDTH-1:0]     coeff [FILTER_ORDER]
);

    logic [COEFF_DATA_WIDTH-1:0] shadow_q [FILTER_ORDER];
    logic [COEFF_DATA_WIDTH-1:0] active_q [FILTER_ORDER];
    logic                        pending_q;
    logic                        pending_d;
    logic                        do_copy;
    logic                        wr_hit;

    // A commit arriving on a boundary cycle is applied immediately and never pends.
    assign do_copy = boundary && (pending_q || commit);
    assign wr_hit  = wr_en && (int'(wr_addr) < int'(FILTER_ORDER));

    always_comb begin
        pending_d = pending_q;
        if (do_copy) begin
            pending_d = 1'b0;
        end else if (commit) begin
            pending_d = 1'b1;
        end
    end

    // Non-blocking copy reads the pre-write shadow when a write lands in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(FILTER_ORDER); i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            pending_q <= 1'b0;
        end else begin
            if (wr_hit) begin
                shadow_q[wr_addr] <= wr_data;
            end
            if (do_copy) begin
                for (int i = 0; i < int'(FILTER_ORDER); i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
            pending_q <= pending_d;
        end
    end

    assign commit_pending = pending_q;
    assign coeff          = active_q;

endmodule

// File: rtl/hbf_sched.sv
// Pairs an input sample stream into even/odd polyphase pairs for the hbf core and
// owns the coefficient bank. HBF_SCHED_STATS_EN adds the stat_pairs counter.
module hbf_sched #(
    parameter int unsigned INPUT_SAMPLE_DATA_WIDTH = filter_pkg::INPUT_SAMPLE_DATA_WIDTH,
    parameter int unsigned COEFF_DATA_WIDTH        = filter_pkg::COEFF_DATA_WIDTH,
    parameter int unsigned FILTER_ORDER            = filter_pkg::FILTER_ORDER
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [INPUT_SAMPLE_DATA_WIDTH-1:0] in_sample,
    input  logic                               flush,
    output logic                               pair_valid,
    input  logic                               pair_ready,
    output logic [INPUT_SAMPLE_DATA_WIDTH-1:0] sample_top,
    output logic [INPUT_SAMPLE_DATA_WIDTH-1:0] sample_bottom,
    input  logic                               coeff_wr_en,
    input  logic [$clog2(FILTER_ORDER)-1:0]    coeff_wr_addr,
    input  logic [COEFF_DATA_WIDTH-1:0]        coeff_wr_data,
    input  logic                               coeff_commit,
    output logic                               commit_pending,
`ifdef HBF_SCHED_STATS_EN
    output logic [15:0]                        stat_pairs,
`endif
    output logic [COEFF_DATA_WIDTH-1:0]        coeff [FILTER_ORDER]
);

    import filter_pkg::*;

    sched_state_t                     state_q, state_d;
    logic [INPUT_SAMPLE_DATA_WIDTH-1:0] top_q, top_d;
    logic [INPUT_SAMPLE_DATA_WIDTH-1:0] bot_q, bot_d;
    logic                             accept;
    logic                             handshake;
    logic                             boundary;

    assign pair_valid = (state_q == S_ISSUE);
    assign handshake  = pair_valid && pair_ready;
    assign boundary   = (state_q == S_EVEN) || handshake;
    assign accept     = in_valid && in_ready;

    always_comb begin
        in_ready = !flush && ((state_q != S_ISSUE) || pair_ready);
    end

    always_comb begin
        state_d = state_q;
        top_d   = top_q;
        bot_d   = bot_q;
        unique case (state_q)
            S_EVEN: begin
                if (accept) begin
                    top_d   = in_sample;
                    state_d = S_ODD;
                end
            end
            S_ODD: begin
                if (flush) begin
                    state_d = S_EVEN;
                end else if (accept) begin
                    bot_d   = in_sample;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Flush only gates in_ready here; the held pair is still delivered.
                if (pair_ready) begin
                    if (accept) begin
                        top_d   = in_sample;
                        state_d = S_ODD;
                    end else begin
                        state_d = S_EVEN;
                    end
                end
            end
            default: state_d = S_EVEN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EVEN;
            top_q   <= '0;
            bot_q   <= '0;
        end else begin
            state_q <= state_d;
            top_q   <= top_d;
            bot_q   <= bot_d;
        end
    end

    assign sample_top    = top_q;
    assign sample_bottom = bot_q;

`ifdef HBF_SCHED_STATS_EN
    logic [15:0] stat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= '0;
        end else if (handshake) begin
            stat_q <= sat_inc16(stat_q);
        end
    end

    assign stat_pairs = stat_q;
`endif

    hbf_coeff_bank #(
        .COEFF_DATA_WIDTH (COEFF_DATA_WIDTH),
        .FILTER_ORDER     (FILTER_ORDER)
    ) u_coeff_bank (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (coeff_wr_en),
        .wr_addr        (coeff_wr_addr),
        .wr_data        (coeff_wr_data),
        .commit         (coeff_commit),
        .boundary       (boundary),
        .commit_pending (commit_pending),
        .coeff          (coeff)
    );

endmodule

// File: tb/tb_hbf_sched.sv
// Directed bench for hbf_sched: table-driven pairing vectors plus hand-written
// coefficient-commit and reset sequences. Stat checks follow HBF_SCHED_STATS_EN.
module tb_hbf_sched;

    import filter_pkg::*;

    localparam int unsigned SW = 16;
    localparam int unsigned CW = 16;
    localparam int unsigned FO = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [SW-1:0]           in_sample;
    logic                    flush;
    logic                    pair_valid;
    logic                    pair_ready;
    logic [SW-1:0]           sample_top;
    logic [SW-1:0]           sample_bottom;
    logic                    coeff_wr_en;
    logic [$clog2(FO)-1:0]   coeff_wr_addr;
    logic [CW-1:0]           coeff_wr_data;
    logic                    coeff_commit;
    logic                    commit_pending;
    logic [CW-1:0]           coeff [FO];
`ifdef HBF_SCHED_STATS_EN
    logic [15:0]             stat_pairs;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hbf_sched #(
        .INPUT_SAMPLE_DATA_WIDTH (SW),
        .COEFF_DATA_WIDTH        (CW),
        .FILTER_ORDER            (FO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_sample      (in_sample),
        .flush          (flush),
        .pair_valid     (pair_valid),
        .pair_ready     (pair_ready),
        .sample_top     (sample_top),
        .sample_bottom  (sample_bottom),
        .coeff_wr_en    (coeff_wr_en),
        .coeff_wr_addr  (coeff_wr_addr),
        .coeff_wr_data  (coeff_wr_data),
        .coeff_commit   (coeff_commit),
        .commit_pending (commit_pending),
`ifdef HBF_SCHED_STATS_EN
        .stat_pairs     (stat_pairs),
`endif
        .coeff          (coeff)
    );

    typedef struct {
        logic          vld;
        logic [SW-1:0] smp;
        logic          fl;
        logic          prdy;
        logic          e_rdy;
        logic          e_pv;
        logic [SW-1:0] e_top;
        logic [SW-1:0] e_bot;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic vld, input logic [SW-1:0] smp, input logic fl,
                                input logic prdy, input logic e_rdy, input logic e_pv,
                                input logic [SW-1:0] e_top, input logic [SW-1:0] e_bot);
        vec_t v;
        v.vld = vld; v.smp = smp; v.fl = fl; v.prdy = prdy;
        v.e_rdy = e_rdy; v.e_pv = e_pv; v.e_top = e_top; v.e_bot = e_bot;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        in_valid   = v.vld;
        in_sample  = v.smp;
        flush      = v.fl;
        pair_ready = v.prdy;
        #3;
        chk($sformatf("v%0d in_ready", idx), {31'd0, in_ready}, {31'd0, v.e_rdy});
        tick();
        chk($sformatf("v%0d pair_valid", idx), {31'd0, pair_valid}, {31'd0, v.e_pv});
        chk($sformatf("v%0d sample_top", idx), {16'd0, sample_top}, {16'd0, v.e_top});
        chk($sformatf("v%0d sample_bottom", idx), {16'd0, sample_bottom}, {16'd0, v.e_bot});
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sample = '0; flush = 1'b0; pair_ready = 1'b0;
        coeff_wr_en = 1'b0; coeff_wr_addr = '0; coeff_wr_data = '0; coeff_commit = 1'b0;

        // vld smp fl prdy | in_ready pair_valid top bottom
        add(1, 1, 0, 1,  1, 0, 1, 0);
        add(1, 2, 0, 1,  1, 1, 1, 2);
        add(1, 3, 0, 1,  1, 0, 3, 2);
        add(1, 4, 0, 1,  1, 1, 3, 4);
        add(0, 0, 0, 1,  1, 0, 3, 4);
        add(1, 5, 0, 1,  1, 0, 5, 4);
        add(1, 6, 0, 1,  1, 1, 5, 6);
        for (int i = 0; i < 4; i++) add(1, 7, 0, 0,  0, 1, 5, 6);
        add(1, 7, 0, 1,  1, 0, 7, 6);
        add(1, 8, 0, 1,  1, 1, 7, 8);
        add(0, 0, 0, 1,  1, 0, 7, 8);
        add(1, 9, 0, 1,  1, 0, 9, 8);
        add(1, 99, 1, 1, 0, 0, 9, 8);
        add(1, 10, 0, 1, 1, 0, 10, 8);
        add(1, 11, 0, 1, 1, 1, 10, 11);
        add(0, 0, 0, 1,  1, 0, 10, 11);
        add(1, 12, 0, 1, 1, 0, 12, 11);
        add(1, 13, 0, 1, 1, 1, 12, 13);
        add(1, 77, 1, 0, 0, 1, 12, 13);
        add(1, 77, 1, 1, 0, 0, 12, 13);
        add(1, 14, 0, 1, 1, 0, 14, 13);
        add(1, 15, 0, 1, 1, 1, 14, 15);
        add(0, 0, 0, 1,  1, 0, 14, 15);

        tick(); tick();
        rst = 1'b0;
        #2;
        chk("rst pair_valid", {31'd0, pair_valid}, 32'd0);
        chk("rst sample_top", {16'd0, sample_top}, 32'd0);
        chk("rst sample_bottom", {16'd0, sample_bottom}, 32'd0);
        chk("rst commit_pending", {31'd0, commit_pending}, 32'd0);
        chk("rst coeff0", {16'd0, coeff[0]}, 32'd0);
        chk("rst in_ready", {31'd0, in_ready}, 32'd1);
`ifdef HBF_SCHED_STATS_EN
        chk("rst stat_pairs", {16'd0, stat_pairs}, 32'd0);
`endif
        tick();

        foreach (vecs[i]) run_vec(vecs[i], i);
        in_valid = 1'b0; flush = 1'b0; pair_ready = 1'b0;

        // Commit raised mid-pair waits for the pair handshake.
        in_valid = 1'b1; in_sample = 16'd20; tick();
        in_valid = 1'b0;
        coeff_wr_en = 1'b1; coeff_wr_addr = 3'd0; coeff_wr_data = 16'h0100; tick();
        coeff_wr_en = 1'b0; coeff_commit = 1'b1; tick();
        coeff_commit = 1'b0;
        chk("odd commit_pending", {31'd0, commit_pending}, 32'd1);
        chk("odd coeff0 held", {16'd0, coeff[0]}, 32'd0);
        in_valid = 1'b1; in_sample = 16'd21; tick();
        in_valid = 1'b0;
        chk("issue pair_valid", {31'd0, pair_valid}, 32'd1);
        chk("issue commit_pending", {31'd0, commit_pending}, 32'd1);
        tick();
        chk("stall coeff0 held", {16'd0, coeff[0]}, 32'd0);
        pair_ready = 1'b1; tick();
        chk("hs pair_valid", {31'd0, pair_valid}, 32'd0);
        chk("hs commit_pending", {31'd0, commit_pending}, 32'd0);
        chk("hs coeff0", {16'd0, coeff[0]}, 32'h0100);

        // Commit in S_EVEN with a same-cycle shadow write copies the old shadow value.
        coeff_wr_en = 1'b1; coeff_wr_addr = 3'd1; coeff_wr_data = 16'd3; coeff_commit = 1'b1;
        tick();
        coeff_wr_en = 1'b0; coeff_commit = 1'b0;
        chk("even commit_pending", {31'd0, commit_pending}, 32'd0);
        chk("even coeff1 old", {16'd0, coeff[1]}, 32'd0);
        chk("even coeff0 kept", {16'd0, coeff[0]}, 32'h0100);
        tick();
        chk("even pending stays low", {31'd0, commit_pending}, 32'd0);
        coeff_commit = 1'b1; tick();
        coeff_commit = 1'b0;
        chk("recommit coeff1", {16'd0, coeff[1]}, 32'd3);

        // Reset while a pair is held and a commit is pending.
        pair_ready = 1'b0;
        in_valid = 1'b1; in_sample = 16'd30; tick();
        in_sample = 16'd31; tick();
        in_valid = 1'b0;
        coeff_wr_en = 1'b1; coeff_wr_addr = 3'd2; coeff_wr_data = 16'd5; coeff_commit = 1'b1;
        tick();
        coeff_wr_en = 1'b0; coeff_commit = 1'b0;
        chk("pre-rst pair_valid", {31'd0, pair_valid}, 32'd1);
        chk("pre-rst commit_pending", {31'd0, commit_pending}, 32'd1);
        rst = 1'b1; tick();
        rst = 1'b0;
        chk("mid rst pair_valid", {31'd0, pair_valid}, 32'd0);
        chk("mid rst sample_top", {16'd0, sample_top}, 32'd0);
        chk("mid rst sample_bottom", {16'd0, sample_bottom}, 32'd0);
        chk("mid rst commit_pending", {31'd0, commit_pending}, 32'd0);
        chk("mid rst coeff1", {16'd0, coeff[1]}, 32'd0);
        chk("mid rst in_ready", {31'd0, in_ready}, 32'd1);
`ifdef HBF_SCHED_STATS_EN
        chk("mid rst stat_pairs", {16'd0, stat_pairs}, 32'd0);
`endif
        tick();
        chk("post rst coeff2", {16'd0, coeff[2]}, 32'd0);
        coeff_commit = 1'b1; tick();
        coeff_commit = 1'b0;
        chk("shadow cleared coeff2", {16'd0, coeff[2]}, 32'd0);

        pair_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_sample = 16'(40 + i); tick();
        end
        in_valid = 1'b0; tick();
        chk("3hs sample_top", {16'd0, sample_top}, 32'd44);
        chk("3hs sample_bottom", {16'd0, sample_bottom}, 32'd45);
        chk("3hs pair_valid", {31'd0, pair_valid}, 32'd0);
`ifdef HBF_SCHED_STATS_EN
        chk("3hs stat_pairs", {16'd0, stat_pairs}, 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
